// File: rtl/nonrestoring_divider32.sv
// Iterative radix-2 non-restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per clock, then a single fix-up cycle. Results are held until the next start.
module nonrestoring_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finished
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FIXUP  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] raw_dividend;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH:0]   d_reg;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_step;
  logic [WIDTH:0]   p_fix;

  // The partial remainder stays within [-D, D), so WIDTH+1 bits with
  // wrap-around arithmetic are enough even though 2P+bit may briefly overflow.
  always_comb begin
    dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    p_shift      = {p_reg[WIDTH-1:0], a_reg[WIDTH-1]};
    p_step       = p_reg[WIDTH] ? (p_shift + d_reg) : (p_shift - d_reg);
    p_fix        = p_reg[WIDTH] ? (p_reg + d_reg) : p_reg;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      count        <= '0;
      a_reg        <= '0;
      raw_dividend <= '0;
      p_reg        <= '0;
      d_reg        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz           <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
    end else if (start) begin
      // A new request wins in every state and discards any in-flight divide.
      state        <= DIVIDE;
      count        <= CW'(WIDTH);
      a_reg        <= dividend_abs;
      d_reg        <= {1'b0, divisor_abs};
      p_reg        <= '0;
      neg_q        <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & (divisor != '0);
      neg_r        <= is_signed & dividend[WIDTH-1];
      dz           <= (divisor == '0);
      raw_dividend <= dividend;
    end else begin
      case (state)
        DIVIDE: begin
          p_reg <= p_step;
          a_reg <= {a_reg[WIDTH-2:0], ~p_step[WIDTH]};
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          p_reg <= p_fix;
          if (dz) begin
            quotient  <= '1;
            remainder <= raw_dividend;
          end else begin
            quotient  <= neg_q ? -a_reg : a_reg;
            remainder <= neg_r ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
          end
          state <= DONE;
        end
        default: ;
      endcase
    end
  end

  // Gated by start so a requester sees busy in the same cycle it issues a new divide.
  assign finished = (state == DONE) && !start;

endmodule

// File: tb/tb_nonrestoring_divider32.sv
// Self-checking bench for nonrestoring_divider32: directed RV32M cases, restart,
// mid-operation reset and randomized operands against a plain-arithmetic model.
module tb_nonrestoring_divider32;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          is_signed = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          finished;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  nonrestoring_divider32 #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
    .finished  (finished)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V division semantics computed with 64-bit host arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (s) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Model: a request captured on a start edge becomes visible W+1 edges later.
  logic [31:0] exp_q = '0, exp_r = '0, pend_q = '0, pend_r = '0;
  logic [31:0] mq, mr;
  logic        exp_done = 1'b0;
  int          rem_edges = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exp_q     <= '0;
      exp_r     <= '0;
      exp_done  <= 1'b0;
      rem_edges <= 0;
    end else if (start) begin
      ref_div(dividend, divisor, is_signed, mq, mr);
      pend_q    <= mq;
      pend_r    <= mr;
      exp_done  <= 1'b0;
      rem_edges <= W + 1;
    end else if (rem_edges > 0) begin
      if (rem_edges == 1) begin
        exp_q    <= pend_q;
        exp_r    <= pend_r;
        exp_done <= 1'b1;
      end
      rem_edges <= rem_edges - 1;
    end
  end

  always @(negedge CLK) begin
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("finished", {31'd0, finished}, {31'd0, exp_done & ~start});
  end

  // Called just after a rising edge; returns just after the start edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    #1 check("finished_low_while_start", {31'd0, finished}, 32'd0);
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!finished && n < 40) begin
      @(posedge CLK);
      #1 n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string tag);
    @(posedge CLK);
    #1 launch(a, b, s);
    wait_done(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_finished", {31'd0, finished}, 32'd0);
    nRST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check("idle_finished", {31'd0, finished}, 32'd0);

    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    check("u100_7_q", quotient, 32'd14);
    check("u100_7_r", remainder, 32'd2);
    repeat (5) @(posedge CLK);
    #1 check("u100_7_hold_q", quotient, 32'd14);
    check("u100_7_hold_fin", {31'd0, finished}, 32'd1);

    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "sm7_2");
    check("sm7_2_q", quotient, 32'hFFFF_FFFD);
    check("sm7_2_r", remainder, 32'hFFFF_FFFF);

    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_m2");
    check("s7_m2_q", quotient, 32'hFFFF_FFFD);
    check("s7_m2_r", remainder, 32'd1);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf");
    check("ovf_q", quotient, 32'h8000_0000);
    check("ovf_r", remainder, 32'd0);

    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "umax");
    check("umax_q", quotient, 32'hFFFF_FFFF);
    check("umax_r", remainder, 32'd0);

    run_div(32'h8000_0005, 32'd0, 1'b1, "dz_s");
    check("dz_s_q", quotient, 32'hFFFF_FFFF);
    check("dz_s_r", remainder, 32'h8000_0005);

    run_div(32'h8000_0005, 32'd0, 1'b0, "dz_u");
    check("dz_u_q", quotient, 32'hFFFF_FFFF);
    check("dz_u_r", remainder, 32'h8000_0005);

    // Restart ten edges into a divide; only the second request completes.
    @(posedge CLK);
    #1 launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge CLK);
    #1 check("restart_prior_q", quotient, 32'hFFFF_FFFF);
    launch(32'd50, 32'd5, 1'b0);
    wait_done("restart");
    check("restart_q", quotient, 32'd10);
    check("restart_r", remainder, 32'd0);

    // Reset fifteen edges into a divide.
    @(posedge CLK);
    #1 launch(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge CLK);
    #1 nRST = 1'b0;
    #1;
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_fin", {31'd0, finished}, 32'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    repeat (40) @(posedge CLK);
    #1 check("midrst_no_finish", {31'd0, finished}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -($urandom_range(1, 9));
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, "rand");
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
